// File: rtl/lsu.sv
// Load/store unit for the M stage: one req/ack bus transaction per access,
// lane steering, load extension, alignment check and bus timeout.
// Ports: clk, rst_n; mm_re/mm_we/funct3/addr/wdata from the M stage;
// rdata, busy_M, misaligned_M, bus_err_M back to the pipeline;
// bus_req/we/addr/be/wdata out and bus_rdata/bus_ack in on the bus.
module lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mm_re,
  input  logic              mm_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy_M,
  output logic              misaligned_M,
  output logic              bus_err_M,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort in WAIT one count early: the IDLE cycle is also a busy cycle,
  // so the whole stall is bounded by TIMEOUT cycles.
  localparam int TLIM = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
  localparam logic [CW-1:0] TLIM_C = CW'(TLIM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          capture;
  logic          abort;

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        mem;
  logic        misal;
  logic        access;
  logic [1:0]  lane;
  logic [31:0] sh;

  assign lane = addr[1:0];
  assign is_b = (funct3 == 3'b000) || (funct3 == 3'b100);
  assign is_h = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign is_w = ~is_b & ~is_h;
  assign mem  = mm_re | mm_we;

  assign misal  = mem & ((is_h & addr[0]) | (is_w & (|lane)));
  assign access = mem & ~misal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == S_IDLE) cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + CW'(1);
      if (capture) rdata_q <= bus_rdata;
      else if (abort) rdata_q <= '0;
      if (state_n == S_DONE) err_q <= abort;
    end
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access) begin
          if (bus_ack) begin
            capture = 1'b1;
            state_n = S_DONE;
          end else if (TIMEOUT == 1) begin
            abort   = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          capture = 1'b1;
          state_n = S_DONE;
        end else if (TIMEOUT >= 2 && cnt == TLIM_C) begin
          abort   = 1'b1;
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req      = rst_n & (((state == S_IDLE) & access) | (state == S_WAIT));
    busy_M       = bus_req;
    misaligned_M = rst_n & misal;
    bus_err_M    = rst_n & (state == S_DONE) & err_q;
  end

  assign bus_we   = mm_we;
  assign bus_addr = {addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    bus_be    = 4'b1111;
    bus_wdata = wdata;
    unique case (1'b1)
      is_b: begin
        bus_be    = 4'b0001 << lane;
        bus_wdata = {4{wdata[7:0]}};
      end
      is_h: begin
        bus_be    = 4'b0011 << lane;
        bus_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh = rdata_q >> {lane, 3'b000};

  always_comb begin
    rdata = rdata_q;
    unique case (1'b1)
      is_b: rdata = {{24{sh[7] & ~funct3[2]}}, sh[7:0]};
      is_h: rdata = {{16{sh[15] & ~funct3[2]}}, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu with TIMEOUT=4: random and directed
// loads/stores, misalignment, timeout and mid-transaction reset.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mm_re = 1'b0;
  logic        mm_we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy_M;
  logic        misaligned_M;
  logic        bus_err_M;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mm_re(mm_re), .mm_we(mm_we),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy_M(busy_M),
    .misaligned_M(misaligned_M), .bus_err_M(bus_err_M),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    bit          ld;
    bit          err;
    int          busy;
    logic [31:0] rdata;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwdata;
    bit          we;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f,
      input logic [31:0] rd, input int ln);
    logic [31:0] s;
    int v;
    s = rd >> (8 * ln);
    case (f)
      3'b000: begin v = int'(s & 32'hFF); if (v >= 128) v -= 256; end
      3'b100: v = int'(s & 32'hFF);
      3'b001: begin v = int'(s & 32'hFFFF); if (v >= 32768) v -= 65536; end
      3'b101: v = int'(s & 32'hFFFF);
      default: v = int'(rd);
    endcase
    return 32'(v);
  endfunction

  function automatic exp_t model(input bit ld, input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] wd,
      input logic [31:0] rd, input int d);
    exp_t e;
    int ln;
    int sz;
    ln = int'(a % 4);
    sz = (f == 3'b000 || f == 3'b100) ? 1 :
         (f == 3'b001 || f == 3'b101) ? 2 : 4;
    e.ld = ld;
    e.we = ~ld;
    e.mis = (a % sz) != 0;
    e.err = (d >= TO);
    e.busy = (d + 1 < TO) ? d + 1 : TO;
    e.rdata = e.err ? 32'h0 : ref_load(f, rd, ln);
    e.baddr = a - (a % 4);
    if (sz == 1) begin
      e.be = 4'(1 << ln);
      e.bwdata = {4{wd[7:0]}};
    end else if (sz == 2) begin
      e.be = 4'(3 << ln);
      e.bwdata = {2{wd[15:0]}};
    end else begin
      e.be = 4'hF;
      e.bwdata = wd;
    end
    return e;
  endfunction

  // Called at posedge+1 in IDLE; returns at posedge+1 after DONE.
  task automatic do_op(input bit ld, input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] wd,
      input logic [31:0] rd, input int d);
    exp_t e;
    int c;
    e = model(ld, f, a, wd, rd, d);
    q.push_back(e);
    mm_re = ld;
    mm_we = ~ld;
    funct3 = f;
    addr = a;
    wdata = wd;
    bus_rdata = rd;
    if (e.mis) begin
      bus_ack = 1'b0;
      @(posedge clk); #1;
    end else begin
      bus_ack = (d == 0);
      c = 0;
      while (1) begin
        @(posedge clk); #1;
        c++;
        if (!busy_M) break;
        if (c > 30) begin
          chk("op_bound", 32'(c), 32'(d + 1));
          break;
        end
        bus_ack = (c == d);
      end
      bus_ack = 1'b0;
      @(posedge clk); #1;
    end
    mm_re = 1'b0;
    mm_we = 1'b0;
  endtask

  int bc = 0;
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      bc = 0;
    end else if (misaligned_M) begin
      if (q.size() == 0) chk("mis_unexp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("mis_flag", 32'(e.mis), 32'd1);
        chk("mis_req", 32'(bus_req), 32'd0);
        chk("mis_busy", 32'(busy_M), 32'd0);
      end
    end else if (busy_M) begin
      bc++;
      if (bc == 1) begin
        if (q.size() == 0) chk("req_unexp", 32'd1, 32'd0);
        else begin
          chk("req", 32'(bus_req), 32'd1);
          chk("bus_addr", bus_addr, q[0].baddr);
          chk("bus_we", 32'(bus_we), 32'(q[0].we));
          chk("bus_be", 32'(bus_be), 32'(q[0].be));
          if (q[0].we) chk("bus_wdata", bus_wdata, q[0].bwdata);
        end
      end
    end else if (bc > 0) begin
      if (q.size() == 0) chk("done_unexp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("busy_cycles", 32'(bc), 32'(e.busy));
        chk("bus_err", 32'(bus_err_M), 32'(e.err));
        chk("done_req", 32'(bus_req), 32'd0);
        if (e.ld) chk("rdata", rdata, e.rdata);
      end
      bc = 0;
    end
  end

  initial begin
    logic [2:0] fs [6];
    fs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_busy", 32'(busy_M), 32'd0);
    chk("rst_mis", 32'(misaligned_M), 32'd0);
    chk("rst_err", 32'(bus_err_M), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_op(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    do_op(1, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 0);
    do_op(1, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 0);
    do_op(0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1);
    do_op(1, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    do_op(1, 3'b010, 32'h104, 32'h0, 32'h11223344, 50);
    do_op(1, 3'b101, 32'h106, 32'h0, 32'h9876FFFF, 3);
    do_op(1, 3'b001, 32'h106, 32'h0, 32'h9876FFFF, 3);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      do_op($urandom_range(0, 1) == 1, fs[$urandom_range(0, 5)],
            a, $urandom, $urandom, $urandom_range(0, 5));
    end

    // Reset while the bus is still waiting on an ack.
    mon_en = 1'b0;
    mm_re = 1'b1;
    funct3 = 3'b010;
    addr = 32'h300;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy_M), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus_req), 32'd0);
    chk("arst_busy", 32'(busy_M), 32'd0);
    mm_re = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    do_op(1, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1);

    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("queue_left", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
